// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: FSM state
// encoding, decoded opcodes and the vector-done redirect address.
package instr_fetch_ctrl_pkg;

    localparam int          IFC_ADDR_MAX = 16;
    localparam logic [3:0]  IFC_JMP_OP   = 4'hC;
    localparam logic [3:0]  IFC_HALT_OP  = 4'hF;

    // Address the PC loads on a vector-done redirect (the PC owns the load,
    // this controller only issues the enable pulse).
    localparam logic [15:0] IFC_VEC_ADDR = 16'hFFF0;

    // FSM encoding, kept as plain constants so legacy code can compare them
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_REDIR = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller. Reads one word at the PC address over a
// req/ack port, offers it downstream on valid/ready, then pulses the PC
// enable (with the jump flag for PC-relative jumps). A vector-done request
// forces a redirect pulse so the PC loads the vector address; HALT stops
// all fetching until reset.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int         ADDR_MAX = IFC_ADDR_MAX,
    parameter logic [3:0] JMP_OP   = IFC_JMP_OP,
    parameter logic [3:0] HALT_OP  = IFC_HALT_OP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_MAX-1:0] pc_addr,
    output logic                pc_enable,
    output logic                pc_jump,
    output logic [ADDR_MAX-1:0] pc_word,
    input  logic                vec_done,
    output logic                mem_req,
    output logic [ADDR_MAX-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [ADDR_MAX-1:0] mem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [ADDR_MAX-1:0] instr,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [ADDR_MAX-1:0] word_q;
    logic [3:0]          opcode;
    logic                accept;
    logic                is_halt;
    logic                load_word;

    assign opcode    = word_q[ADDR_MAX-1 -: 4];
    assign is_halt   = (opcode == HALT_OP);
    // A downstream accept only counts when no redirect is pending.
    assign accept    = (state == S_ISSUE) && instr_ready && !vec_done;
    // Acked data is dropped if a redirect arrives in the same cycle.
    assign load_word = (state == S_REQ) && mem_ack && !vec_done;

    // Next-state logic; vec_done outranks instr_ready everywhere it is sampled
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ: begin
                if (mem_ack)       state_nxt = vec_done ? S_REDIR : S_ISSUE;
                else if (vec_done) state_nxt = S_DRAIN;
            end
            S_ISSUE: begin
                if (vec_done)         state_nxt = S_REDIR;
                else if (instr_ready) state_nxt = is_halt ? S_HALT : S_REQ;
            end
            S_DRAIN: if (mem_ack) state_nxt = S_REDIR;
            S_REDIR: state_nxt = S_REQ;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding memory request
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Fetched word register, shared by the decode and PC offset outputs
    always_ff @(posedge clock) begin
        if (reset)          word_q <= '0;
        else if (load_word) word_q <= mem_rdata;
    end

    // Count of words handed downstream, including the HALT word itself
    always_ff @(posedge clock) begin
        if (reset)       fetch_count <= '0;
        else if (accept) fetch_count <= fetch_count + 16'd1;
    end

    // Port decode from state; the request address tracks the PC only while
    // a request is outstanding (the PC does not move during REQ/DRAIN, so
    // the address stays stable until ack).
    always_comb begin
        mem_req     = (state == S_REQ) || (state == S_DRAIN);
        mem_addr    = mem_req ? pc_addr : '0;
        instr_valid = (state == S_ISSUE);
        pc_enable   = (accept && !is_halt) || (state == S_REDIR);
        pc_jump     = accept && !is_halt && (opcode == JMP_OP);
        halted      = (state == S_HALT);
    end

    assign instr   = word_q;
    assign pc_word = word_q;

endmodule
